// File: rtl/i2s_frame_ctrl_pkg.sv
// Shared types and constants for the I2S frame controller and its pair buffer.
package i2s_frame_ctrl_pkg;

  // Frame sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Underrun behaviour selectors
  localparam int UR_REPEAT = 0;  // keep presenting the last words
  localparam int UR_MUTE   = 1;  // present zero words

  // Number of zero bits appended below a left-justified sample
  function automatic int pad_bits(input int word_size, input int sample_size);
    return word_size - sample_size;
  endfunction

endpackage

// File: rtl/i2s_frame_ctrl_pair_buf.sv
// One-entry stereo holding register. Accepts a pair when empty, releases it on pop.
// A full entry is never overwritten; it only clears on pop or reset.
module i2s_frame_ctrl_pair_buf
  import i2s_frame_ctrl_pkg::*;
#(
  parameter int SAMPLE_SIZE = 24
) (
  input  logic                   bck,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_SIZE-1:0] in_l,
  input  logic [SAMPLE_SIZE-1:0] in_r,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [SAMPLE_SIZE-1:0] out_l,
  output logic [SAMPLE_SIZE-1:0] out_r
);

  logic                   full_reg;
  logic [SAMPLE_SIZE-1:0] l_reg;
  logic [SAMPLE_SIZE-1:0] r_reg;

  // Occupancy flag: set on accept, cleared on pop; accept only when empty
  always_ff @(negedge bck) begin
    if (rst) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  // Sample storage, written only when an accept happens into an empty entry
  always_ff @(negedge bck) begin
    if (rst) begin
      l_reg <= '0;
      r_reg <= '0;
    end else if (in_valid && !full_reg) begin
      l_reg <= in_l;
      r_reg <= in_r;
    end
  end

  assign in_ready  = !full_reg;
  assign out_valid = full_reg;
  assign out_l     = l_reg;
  assign out_r     = r_reg;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Frame sequencer and sample scheduler feeding an I2S serialiser.
// Generates lrck, pulls stereo pairs over valid/ready, buffers one pair and
// presents left-justified words at each frame boundary. Counts underruns.
// All state advances on the falling edge of the bit clock.
module i2s_frame_ctrl
  import i2s_frame_ctrl_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int SAMPLE_SIZE   = 24,
  parameter int UNDERRUN_MODE = 0,
  parameter int CNT_W         = 16
) (
  input  logic                   bck,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMPLE_SIZE-1:0] s_l_sample,
  input  logic [SAMPLE_SIZE-1:0] s_r_sample,
  output logic                   lrck,
  output logic [WORD_SIZE-1:0]   l_word,
  output logic [WORD_SIZE-1:0]   r_word,
  output logic                   frame_start,
  output logic                   underrun,
  output logic [CNT_W-1:0]       underrun_cnt
);

  localparam int CW  = $clog2(WORD_SIZE);
  localparam int PAD = pad_bits(WORD_SIZE, SAMPLE_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);

  state_t                 state_reg;
  logic [CW-1:0]          bit_cnt_reg;
  logic                   lrck_reg;
  logic [WORD_SIZE-1:0]   l_word_reg;
  logic [WORD_SIZE-1:0]   r_word_reg;
  logic                   frame_start_reg;
  logic                   underrun_reg;
  logic [CNT_W-1:0]       underrun_cnt_reg;
  logic                   alive_reg;

  logic                   buf_in_ready;
  logic                   buf_full;
  logic [SAMPLE_SIZE-1:0] buf_l;
  logic [SAMPLE_SIZE-1:0] buf_r;
  logic                   ready;
  logic                   take;
  logic                   boundary;
  logic                   load_edge;
  logic                   buf_push;
  logic                   buf_pop;
  logic [SAMPLE_SIZE-1:0] l_src;
  logic [SAMPLE_SIZE-1:0] r_src;
  logic [WORD_SIZE-1:0]   l_pack;
  logic [WORD_SIZE-1:0]   r_pack;

  // Frame boundary detection, handshake qualification and word packing.
  // In IDLE every edge is a potential entry edge; in RUN only the end of the
  // right slot is. A pair arriving on a load edge with an empty buffer bypasses
  // the buffer and goes straight to the words.
  always_comb begin
    boundary  = (state_reg == ST_IDLE) || ((bit_cnt_reg == LAST) && lrck_reg);
    load_edge = boundary && enable;
    ready     = alive_reg && buf_in_ready;
    take      = s_valid && ready;
    buf_push  = take && !load_edge;
    buf_pop   = load_edge && buf_full;
    l_src     = buf_full ? buf_l : s_l_sample;
    r_src     = buf_full ? buf_r : s_r_sample;
    l_pack    = WORD_SIZE'(l_src) << PAD;
    r_pack    = WORD_SIZE'(r_src) << PAD;
  end

  i2s_frame_ctrl_pair_buf #(
    .SAMPLE_SIZE(SAMPLE_SIZE)
  ) u_pair_buf (
    .bck      (bck),
    .rst      (rst),
    .in_valid (buf_push),
    .in_ready (buf_in_ready),
    .in_l     (s_l_sample),
    .in_r     (s_r_sample),
    .pop      (buf_pop),
    .out_valid(buf_full),
    .out_l    (buf_l),
    .out_r    (buf_r)
  );

  // Frame FSM: slot counting, lrck, word loading and underrun accounting
  always_ff @(negedge bck) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      lrck_reg         <= 1'b0;
      l_word_reg       <= '0;
      r_word_reg       <= '0;
      frame_start_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
      alive_reg        <= 1'b0;
    end else begin
      alive_reg       <= 1'b1;
      frame_start_reg <= load_edge;
      underrun_reg    <= 1'b0;

      unique case (state_reg)
        ST_IDLE: begin
          lrck_reg    <= 1'b0;
          bit_cnt_reg <= '0;
          if (enable) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bit_cnt_reg == LAST) begin
            bit_cnt_reg <= '0;
            lrck_reg    <= !lrck_reg;
            // End of right slot with no run request: park with lrck low
            if (lrck_reg && !enable) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (load_edge) begin
        if (buf_full || take) begin
          l_word_reg <= l_pack;
          r_word_reg <= r_pack;
        end else begin
          underrun_reg <= 1'b1;
          if (underrun_cnt_reg != {CNT_W{1'b1}}) begin
            underrun_cnt_reg <= underrun_cnt_reg + CNT_W'(1);
          end
          if (UNDERRUN_MODE == UR_MUTE) begin
            l_word_reg <= '0;
            r_word_reg <= '0;
          end
        end
      end
    end
  end

  assign s_ready      = ready;
  assign lrck         = lrck_reg;
  assign l_word       = l_word_reg;
  assign r_word       = r_word_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: one repeat-mode instance (16-bit count)
// and one mute-mode instance (4-bit count) share the same stimulus and are
// compared against a frame-position reference model.
module tb_i2s_frame_ctrl;

  logic        bck;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic [23:0] s_l;
  logic [23:0] s_r;

  logic        s_ready0, lrck0, fs0, ur0;
  logic [31:0] l_word0, r_word0;
  logic [15:0] cnt0;
  logic        s_ready1, lrck1, fs1, ur1;
  logic [31:0] l_word1, r_word1;
  logic [3:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  i2s_frame_ctrl #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .UNDERRUN_MODE(0), .CNT_W(16)) dut0 (
    .bck(bck), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready0),
    .s_l_sample(s_l), .s_r_sample(s_r), .lrck(lrck0), .l_word(l_word0), .r_word(r_word0),
    .frame_start(fs0), .underrun(ur0), .underrun_cnt(cnt0)
  );

  i2s_frame_ctrl #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .UNDERRUN_MODE(1), .CNT_W(4)) dut1 (
    .bck(bck), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready1),
    .s_l_sample(s_l), .s_r_sample(s_r), .lrck(lrck1), .l_word(l_word1), .r_word(r_word1),
    .frame_start(fs1), .underrun(ur1), .underrun_cnt(cnt1)
  );

  initial begin
    bck = 1'b1;
    forever #5 bck = ~bck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A frame is 64 bit clocks; m_phase is the position inside the current frame.
  bit          m_alive = 0;
  bit          m_run   = 0;
  int          m_phase = 0;
  logic [23:0] mq_l[$];
  logic [23:0] mq_r[$];
  logic [31:0] m_l0 = '0, m_r0 = '0, m_l1 = '0, m_r1 = '0;
  bit          m_fs = 0, m_ur = 0;
  int          m_cnt = 0;

  function automatic bit e_lrck();
    return m_run && (m_phase >= 32);
  endfunction

  function automatic bit e_ready();
    return m_alive && (mq_l.size() == 0);
  endfunction

  function automatic logic [15:0] e_cnt16();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [3:0] e_cnt4();
    return (m_cnt > 15) ? 4'hF : 4'(m_cnt);
  endfunction

  task automatic model_step();
    bit take, used, boundary;
    logic [23:0] l, r;
    if (rst) begin
      m_alive = 0; m_run = 0; m_phase = 0;
      mq_l.delete(); mq_r.delete();
      m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0;
      m_fs = 0; m_ur = 0; m_cnt = 0;
      return;
    end
    take     = s_valid && e_ready();
    used     = 0;
    m_fs     = 0;
    m_ur     = 0;
    boundary = !m_run || (m_phase == 63);
    if (!boundary) begin
      m_phase++;
    end else begin
      m_phase = 0;
      if (!enable) begin
        m_run = 0;
      end else begin
        m_run = 1;
        m_fs  = 1;
        if (mq_l.size() > 0) begin
          l = mq_l.pop_front();
          r = mq_r.pop_front();
          m_l0 = {l, 8'h00}; m_r0 = {r, 8'h00}; m_l1 = m_l0; m_r1 = m_r0;
        end else if (take) begin
          used = 1;
          m_l0 = {s_l, 8'h00}; m_r0 = {s_r, 8'h00}; m_l1 = m_l0; m_r1 = m_r0;
        end else begin
          m_ur = 1;
          m_cnt++;
          m_l1 = '0; m_r1 = '0;
        end
      end
    end
    if (take && !used) begin
      mq_l.push_back(s_l);
      mq_r.push_back(s_r);
    end
    m_alive = 1;
  endtask

  // One bit clock: DUT and model both advance on the falling edge, outputs
  // are then examined 2 time units later, well away from either edge.
  task automatic tick();
    @(negedge bck);
    model_step();
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; enable = 0; s_valid = 0; s_l = '0; s_r = '0;
    repeat (3) tick();
    n_cmp++; if (lrck0 !== 1'b0) begin n_bad++; $display("FAIL reset_lrck: got %0h want 0", lrck0); end
    n_cmp++; if (l_word0 !== 32'h0 || r_word0 !== 32'h0) begin n_bad++; $display("FAIL reset_words: got %h/%h want 0/0", l_word0, r_word0); end
    n_cmp++; if (s_ready0 !== 1'b0 || s_ready1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0h/%0h want 0/0", s_ready0, s_ready1); end
    n_cmp++; if (cnt0 !== 16'h0 || fs0 !== 1'b0 || ur0 !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got cnt=%0h fs=%0h ur=%0h want 0", cnt0, fs0, ur0); end
    rst = 0;
    tick();
    n_cmp++; if (s_ready0 !== 1'b1 || s_ready1 !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %0h/%0h want 1/1", s_ready0, s_ready1); end
    $display("reset: ready=%0h lrck=%0h", s_ready0, lrck0);
  endtask

  task automatic test_prefill_entry();
    s_l = 24'h123456; s_r = 24'hFEDCBA; s_valid = 1;
    tick();
    s_valid = 0;
    n_cmp++; if (s_ready0 !== 1'b0) begin n_bad++; $display("FAIL prefill_ready: got %0h want 0", s_ready0); end
    n_cmp++; if (l_word0 !== 32'h0) begin n_bad++; $display("FAIL prefill_noload: got %h want 0", l_word0); end
    enable = 1;
    tick();
    n_cmp++; if (l_word0 !== 32'h12345600 || r_word0 !== 32'hFEDCBA00) begin n_bad++; $display("FAIL entry_words: got %h/%h want 12345600/fedcba00", l_word0, r_word0); end
    n_cmp++; if (l_word1 !== 32'h12345600 || r_word1 !== 32'hFEDCBA00) begin n_bad++; $display("FAIL entry_words_mute: got %h/%h want 12345600/fedcba00", l_word1, r_word1); end
    n_cmp++; if (fs0 !== 1'b1 || lrck0 !== 1'b0 || s_ready0 !== 1'b1) begin n_bad++; $display("FAIL entry_flags: got fs=%0h lrck=%0h rdy=%0h want 1/0/1", fs0, lrck0, s_ready0); end
    $display("entry: l_word=%h r_word=%h fs=%0h", l_word0, r_word0, fs0);
    for (int i = 1; i < 64; i++) begin
      tick();
      n_cmp++; if (lrck0 !== (i >= 32) || fs0 !== 1'b0) begin n_bad++; $display("FAIL frame_lrck[%0d]: got lrck=%0h fs=%0h want lrck=%0h fs=0", i, lrck0, fs0, (i >= 32)); end
    end
  endtask

  task automatic test_underrun();
    tick();  // 64 bit clocks after entry, nothing supplied
    n_cmp++; if (fs0 !== 1'b1 || ur0 !== 1'b1 || cnt0 !== 16'd1) begin n_bad++; $display("FAIL ur_repeat_flags: got fs=%0h ur=%0h cnt=%0d want 1/1/1", fs0, ur0, cnt0); end
    n_cmp++; if (l_word0 !== 32'h12345600 || r_word0 !== 32'hFEDCBA00) begin n_bad++; $display("FAIL ur_repeat_words: got %h/%h want 12345600/fedcba00", l_word0, r_word0); end
    n_cmp++; if (l_word1 !== 32'h0 || r_word1 !== 32'h0 || ur1 !== 1'b1 || cnt1 !== 4'd1) begin n_bad++; $display("FAIL ur_mute: got %h/%h ur=%0h cnt=%0d want 0/0/1/1", l_word1, r_word1, ur1, cnt1); end
    tick();
    n_cmp++; if (ur0 !== 1'b0 || fs0 !== 1'b0) begin n_bad++; $display("FAIL ur_pulse_width: got ur=%0h fs=%0h want 0/0", ur0, fs0); end
    $display("underrun: cnt=%0d l_word=%h muted=%h", cnt0, l_word0, l_word1);
  endtask

  task automatic test_bypass();
    logic [23:0] l, r;
    s_valid = 0;
    for (int g = 0; g < 200 && m_phase != 63; g++) tick();
    l = 24'($urandom); r = 24'($urandom);
    s_l = l; s_r = r; s_valid = 1;
    tick();
    s_valid = 0;
    n_cmp++; if (l_word0 !== {l, 8'h00} || r_word0 !== {r, 8'h00}) begin n_bad++; $display("FAIL bypass_words: got %h/%h want %h/%h", l_word0, r_word0, {l, 8'h00}, {r, 8'h00}); end
    n_cmp++; if (ur0 !== 1'b0 || fs0 !== 1'b1 || cnt0 !== 16'd1) begin n_bad++; $display("FAIL bypass_flags: got ur=%0h fs=%0h cnt=%0d want 0/1/1", ur0, fs0, cnt0); end
    n_cmp++; if (s_ready0 !== 1'b1 || l_word1 !== {l, 8'h00}) begin n_bad++; $display("FAIL bypass_ready: got rdy=%0h l1=%h want 1/%h", s_ready0, l_word1, {l, 8'h00}); end
    $display("bypass: l_word=%h r_word=%h", l_word0, r_word0);
  endtask

  task automatic test_disable();
    for (int g = 0; g < 200 && m_phase != 10; g++) tick();
    enable = 0;
    for (int g = 0; g < 200 && m_phase != 63; g++) tick();
    n_cmp++; if (lrck0 !== 1'b1) begin n_bad++; $display("FAIL disable_finish: got lrck=%0h want 1 before frame end", lrck0); end
    tick();
    n_cmp++; if (fs0 !== 1'b0 || lrck0 !== 1'b0 || ur0 !== 1'b0) begin n_bad++; $display("FAIL disable_stop: got fs=%0h lrck=%0h ur=%0h want 0/0/0", fs0, lrck0, ur0); end
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++; if (fs0 !== 1'b0 || lrck0 !== 1'b0 || ur0 !== 1'b0) begin n_bad++; $display("FAIL disable_idle[%0d]: got fs=%0h lrck=%0h ur=%0h want 0/0/0", i, fs0, lrck0, ur0); end
    end
    $display("disable: idle lrck=%0h cnt=%0d", lrck0, cnt0);
  endtask

  task automatic test_saturate();
    int pulses = 0;
    rst = 1; enable = 0; s_valid = 0;
    tick();
    rst = 0;
    tick();
    enable = 1;
    repeat (16 * 64 + 1) begin
      tick();
      if (ur1 === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 17) begin n_bad++; $display("FAIL sat_pulses: got %0d want 17", pulses); end
    n_cmp++; if (cnt1 !== 4'hF) begin n_bad++; $display("FAIL sat_cnt4: got %0h want f", cnt1); end
    n_cmp++; if (cnt0 !== 16'd17) begin n_bad++; $display("FAIL sat_cnt16: got %0d want 17", cnt0); end
    $display("saturate: pulses=%0d cnt4=%0h cnt16=%0d", pulses, cnt1, cnt0);
  endtask

  task automatic test_random();
    int frames = 0;
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      s_valid = ($urandom_range(0, 3) != 0);
      s_l     = 24'($urandom);
      s_r     = 24'($urandom);
      tick();
      if (fs0 === 1'b1) frames++;
      n_cmp++; if (lrck0 !== e_lrck() || lrck1 !== e_lrck()) begin n_bad++; $display("FAIL rnd_lrck t=%0t: got %0h/%0h want %0h", $time, lrck0, lrck1, e_lrck()); end
      n_cmp++; if (s_ready0 !== e_ready() || s_ready1 !== e_ready()) begin n_bad++; $display("FAIL rnd_ready t=%0t: got %0h/%0h want %0h", $time, s_ready0, s_ready1, e_ready()); end
      n_cmp++; if (l_word0 !== m_l0 || r_word0 !== m_r0) begin n_bad++; $display("FAIL rnd_words0 t=%0t: got %h/%h want %h/%h", $time, l_word0, r_word0, m_l0, m_r0); end
      n_cmp++; if (l_word1 !== m_l1 || r_word1 !== m_r1) begin n_bad++; $display("FAIL rnd_words1 t=%0t: got %h/%h want %h/%h", $time, l_word1, r_word1, m_l1, m_r1); end
      n_cmp++; if (fs0 !== m_fs || fs1 !== m_fs) begin n_bad++; $display("FAIL rnd_fs t=%0t: got %0h/%0h want %0h", $time, fs0, fs1, m_fs); end
      n_cmp++; if (ur0 !== m_ur || ur1 !== m_ur) begin n_bad++; $display("FAIL rnd_ur t=%0t: got %0h/%0h want %0h", $time, ur0, ur1, m_ur); end
      n_cmp++; if (cnt0 !== e_cnt16() || cnt1 !== e_cnt4()) begin n_bad++; $display("FAIL rnd_cnt t=%0t: got %0h/%0h want %0h/%0h", $time, cnt0, cnt1, e_cnt16(), e_cnt4()); end
    end
    $display("random: frames=%0d underruns=%0d", frames, m_cnt);
  endtask

  initial begin
    rst = 1; enable = 0; s_valid = 0; s_l = '0; s_r = '0;
    test_reset();
    test_prefill_entry();
    test_underrun();
    test_bypass();
    test_disable();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
